// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the two-input data selector.
//   MUX_DATA_W : default data width
//   MUX_CNT_W  : default switch-counter width
//   sel_e      : named select values for callers (SEL_IN1 = 0, SEL_IN2 = 1)
package mux_pkg;

    localparam int MUX_DATA_W = 32;
    localparam int MUX_CNT_W  = 16;

    typedef enum logic {
        SEL_IN1 = 1'b0,
        SEL_IN2 = 1'b1
    } sel_e;

endpackage

// File: rtl/mux_sel_mon.sv
// mux_sel_mon: debug monitor for the mux select line.
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   ctr      in   select line being watched
//   sel_q    out  ctr as sampled on the previous edge
//   swap_cnt out  saturating count of edges where ctr != sel_q
module mux_sel_mon
    import mux_pkg::*;
#(
    parameter int CNT_W = MUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctr,
    output logic             sel_q,
    output logic [CNT_W-1:0] swap_cnt
);

    // A select change is seen against the previously sampled value, so the
    // first edge after reset compares against sel_q = 0.
    logic swap;
    assign swap = (ctr != sel_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q    <= 1'b0;
            swap_cnt <= '0;
        end else begin
            sel_q <= ctr;
            // Hold at all-ones instead of wrapping so a debug read never
            // under-reports activity.
            if (swap && (swap_cnt != {CNT_W{1'b1}}))
                swap_cnt <= swap_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mux.sv
// mux: two-input WIDTH-bit data selector with select-activity monitor.
//   clk      in   clock for monitor and optional output register
//   rst      in   synchronous active-high reset
//   in1      in   data chosen when ctr = 0
//   in2      in   data chosen when ctr = 1
//   ctr      in   select
//   out      out  selected data
//   sel_q    out  ctr registered on the previous edge
//   swap_cnt out  saturating count of select switches
// Build option MUX_OUT_REG_EN: when defined, out comes from a flop (one
// cycle latency, reset to 0); otherwise out is purely combinational and does
// not depend on clk or rst.
module mux
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DATA_W,
    parameter int CNT_W = MUX_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             ctr,
    output logic [WIDTH-1:0] out,
    output logic             sel_q,
    output logic [CNT_W-1:0] swap_cnt
);

    logic [WIDTH-1:0] mux_d;

    // Explicit case rather than ?: so an unknown select yields all-X in
    // simulation instead of a bitwise merge of the two inputs.
    always_comb begin
        mux_d = '0;
        case (sel_e'(ctr))
            SEL_IN1: mux_d = in1;
            SEL_IN2: mux_d = in2;
            default: mux_d = 'x;
        endcase
    end

`ifdef MUX_OUT_REG_EN
    always_ff @(posedge clk) begin
        if (rst) out <= '0;
        else     out <= mux_d;
    end
`else
    assign out = mux_d;
`endif

    mux_sel_mon #(
        .CNT_W (CNT_W)
    ) u_sel_mon (
        .clk      (clk),
        .rst      (rst),
        .ctr      (ctr),
        .sel_q    (sel_q),
        .swap_cnt (swap_cnt)
    );

endmodule

// File: tb/tb_mux.sv
module tb_mux;
    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clk_run = 1'b0;
    logic             rst = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             ctr = 1'b0;
    logic [WIDTH-1:0] out;
    logic             sel_q;
    logic [CNT_W-1:0] swap_cnt;

    int checks = 0;
    int errors = 0;

    mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in1      (in1),
        .in2      (in2),
        .ctr      (ctr),
        .out      (out),
        .sel_q    (sel_q),
        .swap_cnt (swap_cnt)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational path with no clock edges and reset low.
    task automatic test_comb();
`ifndef MUX_OUT_REG_EN
        in1 = 32'h16a; in2 = 32'h10f; ctr = 1'b0;
        #1;
        checks++;
        if (out !== 32'h16a) begin
            errors++;
            $display("FAIL comb_ctr0: out=%h expected=%h", out, 32'h16a);
        end
        ctr = 1'b1;
        #1;
        checks++;
        if (out !== 32'h10f) begin
            errors++;
            $display("FAIL comb_ctr1: out=%h expected=%h", out, 32'h10f);
        end
`endif
    endtask

    task automatic test_reset();
        clk_run = 1'b1;
        ctr = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (sel_q !== 1'b0) begin
            errors++;
            $display("FAIL reset_sel_q: sel_q=%b expected=0", sel_q);
        end
        checks++;
        if (swap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_swap_cnt: swap_cnt=%0d expected=0", swap_cnt);
        end
`ifdef MUX_OUT_REG_EN
        checks++;
        if (out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: out=%h expected=0", out);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_width();
        logic [WIDTH-1:0] exp;
        in1 = 32'hFFFF_FFFF; in2 = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            ctr = i[0];
            exp = i[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
`ifdef MUX_OUT_REG_EN
            tick();
`else
            #1;
`endif
            checks++;
            if (out !== exp) begin
                errors++;
                $display("FAIL width_toggle%0d: out=%h expected=%h", i, out, exp);
            end
        end
    endtask

    task automatic test_count();
        ctr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ctr = 1'b1;
        tick();
        checks++;
        if (swap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL count_first_edge: swap_cnt=%0d expected=1", swap_cnt);
        end
        tick();
        tick();
        checks++;
        if (swap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL count_hold: swap_cnt=%0d expected=1", swap_cnt);
        end
        checks++;
        if (sel_q !== 1'b1) begin
            errors++;
            $display("FAIL count_sel_q: sel_q=%b expected=1", sel_q);
        end
    endtask

    task automatic test_saturation();
        ctr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ctr = ~i[0];
            tick();
            if (i == 13) begin
                checks++;
                if (swap_cnt !== 4'd14) begin
                    errors++;
                    $display("FAIL sat_edge14: swap_cnt=%0d expected=14", swap_cnt);
                end
            end
            if (i == 15) begin
                checks++;
                if (swap_cnt !== 4'd15) begin
                    errors++;
                    $display("FAIL sat_edge16: swap_cnt=%0d expected=15", swap_cnt);
                end
            end
        end
        checks++;
        if (swap_cnt !== 4'd15) begin
            errors++;
            $display("FAIL sat_final: swap_cnt=%0d expected=15", swap_cnt);
        end
    endtask

    task automatic test_reset_priority();
        ctr = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        ctr = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (swap_cnt !== 4'd0) begin
            errors++;
            $display("FAIL prio_swap_cnt: swap_cnt=%0d expected=0", swap_cnt);
        end
        checks++;
        if (sel_q !== 1'b0) begin
            errors++;
            $display("FAIL prio_sel_q: sel_q=%b expected=0", sel_q);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (swap_cnt !== 4'd1) begin
            errors++;
            $display("FAIL prio_resume: swap_cnt=%0d expected=1", swap_cnt);
        end
    endtask

    task automatic test_equal();
        in1 = 32'hA5A5_0F0F; in2 = 32'hA5A5_0F0F;
        for (int i = 0; i < 2; i++) begin
            ctr = i[0];
`ifdef MUX_OUT_REG_EN
            tick();
`else
            #1;
`endif
            checks++;
            if (out !== 32'hA5A5_0F0F) begin
                errors++;
                $display("FAIL equal_ctr%0d: out=%h expected=%h", i, out, 32'hA5A5_0F0F);
            end
        end
    endtask

    task automatic test_out_reg();
`ifdef MUX_OUT_REG_EN
        in1 = 32'h0; in2 = 32'h0; ctr = 1'b0;
        tick();
        in1 = 32'h16a;
        #1;
        checks++;
        if (out !== 32'h0) begin
            errors++;
            $display("FAIL reg_before_edge: out=%h expected=0", out);
        end
        tick();
        checks++;
        if (out !== 32'h16a) begin
            errors++;
            $display("FAIL reg_after_edge: out=%h expected=%h", out, 32'h16a);
        end
`endif
    endtask

    initial begin
        test_comb();
        test_reset();
        test_width();
        test_count();
        test_saturation();
        test_reset_priority();
        test_equal();
        test_out_reg();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux.md
# mux

Two-input, WIDTH-bit data selector for the pipelined RISC-V core, used wherever a stage chooses between two candidate words (next-PC, ALU operand B, write-back data). The data path is purely combinational by default, so it adds no pipeline latency. A small clocked side block tracks the select line and counts select switches for debug. An optional output register can be compiled in for timing closure.

## Interface
Parameters:
- WIDTH, 32, data width of in1/in2/out.
- CNT_W, 16, width of the switch counter.

Ports:
- clk  input  1  rising-edge clock for the sel_q/swap_cnt logic and the optional output register.
- rst  input  1  synchronous, active-high reset.
- in1  input  WIDTH  data selected when ctr = 0.
- in2  input  WIDTH  data selected when ctr = 1.
- ctr  input  1  select: 0 -> in1, 1 -> in2.
- out  output  WIDTH  selected data.
- sel_q  output  1  ctr registered on the previous clk edge.
- swap_cnt  output  CNT_W  saturating count of clock edges where ctr != sel_q.

## Operation
- out = ctr ? in2 : in1, full WIDTH, no truncation or extension.
- ctr = X/Z: out = X in simulation. No synthesis-time default exists.
- The default-build data path does not depend on clk or rst. With clk/rst undriven, out is still correct.
- sel_q <= ctr on every clk edge while rst = 0.
- swap_cnt increments by 1 on each edge where ctr != sel_q. It holds at all-ones (saturates), never wraps.
- in1 == in2: out equals that value regardless of ctr.

## Timing
- Default build: out is combinational, zero cycles of latency. Any input change propagates within the same delta/settle time.
- rst = 1 at a clk edge: sel_q <= 0 and swap_cnt <= 0. out is unaffected (combinational).
- Reset has priority over counting when it coincides with a select change.
- Reset deasserted mid-operation: counting resumes on the next edge. The comparison uses sel_q = 0.
- With MUX_OUT_REG_EN:
  - out is registered: one clk cycle of latency.
  - Reset value of out is 0.
  - sel_q/swap_cnt timing is unchanged.

## Configuration
- MUX_OUT_REG_EN defined: out is driven from a WIDTH-bit flop loaded with the mux result every clk edge, and cleared by rst.
- MUX_OUT_REG_EN undefined (default): out is driven directly by the combinational mux. No flop exists on the data path.

## Structure
- A shared package mux_pkg holds:
  - the MUX_DATA_W = 32 default;
  - a sel_e enum (SEL_IN1 = 0, SEL_IN2 = 1) for callers.
- One natural sub-module is mux_sel_mon, containing sel_q and the saturating swap_cnt.
- The top level holds the mux and the ifdef-guarded output register.

## Test plan
- Default build, clk/rst undriven:
  - in1 = 0x16a, in2 = 0x10f, ctr = 0 -> out = 0x16a after settle.
  - ctr -> 1 with the same data -> out = 0x10f.
- in1 = 0xFFFFFFFF, in2 = 0x00000000: toggle ctr 0/1 -> out alternates between the full-width values, with no bit loss in the upper bits.
- Reset:
  - assert rst for 1 edge -> sel_q = 0, swap_cnt = 0.
  - ctr = 1 for 3 edges -> swap_cnt = 1, sel_q = 1.
- Saturation: with CNT_W = 4, toggle ctr every edge for 20 edges -> swap_cnt stops at 15.
- MUX_OUT_REG_EN build:
  - rst -> out = 0.
  - in1 = 0x16a, ctr = 0 -> out = 0x16a one edge later, not before.
- Simultaneous rst = 1 and a ctr change at the same edge -> swap_cnt = 0, sel_q = 0.
